// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus responder: FSM states, command opcode
// masks, default busy durations and the clear-display fill character.
package lcd_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUSY} lcdState_e;

  localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;
  localparam logic [7:0] CMD_SET_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_FUNC_SET    = 8'h20;
  localparam logic [7:0] CMD_SHIFT       = 8'h10;
  localparam logic [7:0] CMD_DISP_CTRL   = 8'h08;
  localparam logic [7:0] CMD_ENTRY_MODE  = 8'h04;
  localparam logic [7:0] CMD_RETURN_HOME = 8'h02;
  localparam logic [7:0] CMD_CLEAR       = 8'h01;

  localparam int unsigned CLEAR_CYCLES_DEF = 82000;
  localparam int unsigned CMD_CYCLES_DEF   = 2000;
  localparam int unsigned FILL_LEN         = 128;

  localparam logic [7:0] FILL_CHAR    = 8'h20;
  localparam logic [2:0] FUNC_SET_RST = 3'b100;

  // One-hot of the highest set bit; command decode keys off this.
  function automatic logic [7:0] topBit(input logic [7:0] db);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (db[i]) r = 8'(1) << i;
    return r;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display data RAM: one synchronous write port, an asynchronous bus
// read port and an asynchronous debug view port. No reset on the array.
module lcd_ddram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] wAddr,
  input  logic [7:0] wData,
  input  logic [6:0] rAddr,
  output logic [7:0] rData,
  input  logic [6:0] vAddr,
  output logic [7:0] vData
);

  logic [7:0] mem [128];

  always_ff @(posedge clk)
    if (we) mem[wAddr] <= wData;

  assign rData = mem[rAddr];
  assign vData = mem[vAddr];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder. Define LCD_RESP_BUSY_TIMING_EN for real
// busy durations; otherwise BUSY is 1 cycle (clear display: the 128 fill cycles).
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int unsigned CMD_CYCLES   = CMD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcdEnableIn,
  input  logic       lcdRsSelect,
  input  logic       lcdReadWriteSel,
  input  logic [7:0] lcdBusIn,
  output logic [7:0] lcdBusOut,
  output logic       lcdBusOutEn,
  output logic       busyFlag,
  output logic [6:0] addrCounter,
  output logic [2:0] dispCtrl,
  input  logic [6:0] viewAddr,
  output logic [7:0] viewData,
  output logic       busyViolation
);

`ifdef LCD_RESP_BUSY_TIMING_EN
  localparam bit TIMING_EN = 1'b1;
`else
  localparam bit TIMING_EN = 1'b0;
`endif
  localparam int unsigned CLR_DUR  = TIMING_EN ? CLEAR_CYCLES : FILL_LEN;
  localparam int unsigned HOME_DUR = TIMING_EN ? CLEAR_CYCLES : 1;
  localparam int unsigned CMD_DUR  = TIMING_EN ? CMD_CYCLES   : 1;

  lcdState_e       state, stateNext;
  logic [1:0]      eSy, rsSy, rwSy;
  logic [1:0][7:0] dbSy;
  logic            ePrev, eSync, eRise, eFall;
  logic            pend, latRs, latRw;
  logic [7:0]      latDb;
  logic            incr, entryS, fillOn;
  logic [2:0]      funcSet;
  logic [6:0]      fillAddr, acStep;
  logic [31:0]     busyCnt;
  logic            goExec, memWe;
  logic [6:0]      memWAddr;
  logic [7:0]      memWData, rdData;
  logic            unusedCfg;

  // {DL,N,F} and S are held for completeness; nothing downstream consumes them.
  assign unusedCfg = ^{funcSet, entryS};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      eSy <= '0; rsSy <= '0; rwSy <= '0; dbSy <= '0; ePrev <= 1'b0;
    end else begin
      eSy   <= {eSy[0], lcdEnableIn};
      rsSy  <= {rsSy[0], lcdRsSelect};
      rwSy  <= {rwSy[0], lcdReadWriteSel};
      dbSy  <= {dbSy[0], lcdBusIn};
      ePrev <= eSy[1];
    end

  assign eSync       = eSy[1];
  assign eRise       = eSync & ~ePrev;
  assign eFall       = ~eSync & ePrev;
  assign lcdBusOutEn = eSync & rwSy[1];
  assign busyFlag    = (state != S_IDLE);
  assign acStep      = incr ? addrCounter + 7'd1 : addrCounter - 7'd1;

  // Status reads and the 0x00 no-op never occupy the controller.
  assign goExec = pend && !(!latRs && latRw) && !(!latRs && !latRw && latDb == 8'h00);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= stateNext;

  always_comb begin
    stateNext     = state;
    busyViolation = 1'b0;
    case (state)
      S_IDLE:  if (goExec) stateNext = S_EXEC;
      S_EXEC:  stateNext = S_BUSY;
      S_BUSY:  if (busyCnt == 32'd0) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    // Data reads arriving while busy are served on the bus but do not step AC.
    if (pend && !latRw && state != S_IDLE) busyViolation = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend <= 1'b0; latRs <= 1'b0; latRw <= 1'b0; latDb <= '0;
      addrCounter <= '0; incr <= 1'b1; entryS <= 1'b0;
      dispCtrl <= '0; funcSet <= FUNC_SET_RST;
      busyCnt <= '0; fillOn <= 1'b0; fillAddr <= '0; lcdBusOut <= '0;
    end else begin
      pend <= eFall;
      if (eFall) begin
        latRs <= rsSy[1]; latRw <= rwSy[1]; latDb <= dbSy[1];
      end
      if (eRise && rwSy[1])
        lcdBusOut <= rsSy[1] ? rdData : {busyFlag, addrCounter};
      case (state)
        S_EXEC: begin
          busyCnt <= CMD_DUR - 1;
          if (latRs) addrCounter <= acStep;
          else begin
            case (topBit(latDb))
              CMD_SET_DDRAM:  addrCounter <= latDb[6:0];
              CMD_SET_CGRAM, CMD_SHIFT: ;
              CMD_FUNC_SET:   funcSet <= latDb[4:2];
              CMD_DISP_CTRL:  dispCtrl <= latDb[2:0];
              CMD_ENTRY_MODE: begin incr <= latDb[1]; entryS <= latDb[0]; end
              CMD_RETURN_HOME: begin
                addrCounter <= '0;
                busyCnt     <= HOME_DUR - 1;
              end
              CMD_CLEAR: begin
                addrCounter <= '0; incr <= 1'b1;
                fillOn <= 1'b1; fillAddr <= '0;
                busyCnt <= CLR_DUR - 1;
              end
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (busyCnt != 32'd0) busyCnt <= busyCnt - 32'd1;
          if (fillOn) begin
            fillAddr <= fillAddr + 7'd1;
            if (fillAddr == 7'h7F) fillOn <= 1'b0;
          end
        end
        default: ;
      endcase
    end

  always_comb begin
    memWe    = 1'b0;
    memWAddr = addrCounter;
    memWData = latDb;
    if (state == S_BUSY && fillOn) begin
      memWe    = 1'b1;
      memWAddr = fillAddr;
      memWData = FILL_CHAR;
    end else if (state == S_EXEC && latRs && !latRw) begin
      memWe = 1'b1;
    end
  end

  lcd_ddram uDdram (
    .clk   (clk),
    .we    (memWe),
    .wAddr (memWAddr),
    .wData (memWData),
    .rAddr (addrCounter),
    .rData (rdData),
    .vAddr (viewAddr),
    .vData (viewData)
  );

endmodule
